// File: rtl/axis_adc_decimator.sv
// Two-lane boxcar decimator for packed {ch B, ch A} ADC samples: sums R samples, shifts, emits one pair.
// Build option DEC_SATURATE_EN: clamp each shifted lane to 16-bit signed range instead of wrapping.
module axis_adc_decimator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16,
    parameter int ACC_WIDTH        = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic [4:0]                  cfg_shift,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        sts_overflow
);
    localparam int LANE = 16;
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

    // state | meaning
    // IDLE  | ratio is 0, samples ignored
    // RUN   | accumulating frames of r_reg samples
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                       r_state, w_state_nxt;
    logic [CNTR_WIDTH-1:0]        r_reg, r_cnt, w_ratio;
    logic signed [ACC_WIDTH-1:0]  r_acc_a, r_acc_b;
    logic signed [ACC_WIDTH-1:0]  w_base_a, w_base_b, w_sum_a, w_sum_b, w_shf_a, w_shf_b;
    logic signed [LANE-1:0]       w_x_a, w_x_b, w_lane_a, w_lane_b;
    logic [AXIS_TDATA_WIDTH-1:0]  r_tdata;
    logic                         r_tvalid, r_overflow, r_tready;
    logic                         w_accept, w_last;

`ifdef DEC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] LANE_MAX = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] LANE_MIN = -ACC_WIDTH'(32768);

    function automatic logic signed [LANE-1:0] lane_reduce(input logic signed [ACC_WIDTH-1:0] v);
        if (v > LANE_MAX)      return 16'sh7FFF;
        else if (v < LANE_MIN) return 16'sh8000;
        else                   return LANE'(v);
    endfunction
`else
    function automatic logic signed [LANE-1:0] lane_reduce(input logic signed [ACC_WIDTH-1:0] v);
        return LANE'(v);
    endfunction
`endif

    assign w_x_a    = s_axis_tdata[LANE-1:0];
    assign w_x_b    = s_axis_tdata[2*LANE-1:LANE];
    // First sample of a frame restarts the sum instead of adding to the stale one.
    assign w_base_a = (r_cnt == '0) ? '0 : r_acc_a;
    assign w_base_b = (r_cnt == '0) ? '0 : r_acc_b;
    assign w_sum_a  = w_base_a + {{(ACC_WIDTH-LANE){w_x_a[LANE-1]}}, w_x_a};
    assign w_sum_b  = w_base_b + {{(ACC_WIDTH-LANE){w_x_b[LANE-1]}}, w_x_b};
    assign w_shf_a  = w_sum_a >>> cfg_shift;
    assign w_shf_b  = w_sum_b >>> cfg_shift;
    assign w_lane_a = lane_reduce(w_shf_a);
    assign w_lane_b = lane_reduce(w_shf_b);

    always_comb begin
        w_state_nxt = r_state;
        w_ratio     = r_reg;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ratio = cfg_data;
                if (cfg_data != '0) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt == '0) w_ratio = cfg_data;
                if (w_ratio == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_accept = s_axis_tvalid;
                    w_last   = s_axis_tvalid && (r_cnt == w_ratio - CNT_ONE);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= ST_IDLE;
            r_reg      <= '0;
            r_cnt      <= '0;
            r_acc_a    <= '0;
            r_acc_b    <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_overflow <= 1'b0;
            r_tready   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_reg    <= w_ratio;
            r_tready <= 1'b1;
            if (w_accept) begin
                r_cnt   <= w_last ? '0 : r_cnt + CNT_ONE;
                r_acc_a <= w_sum_a;
                r_acc_b <= w_sum_b;
            end
            // A held word that downstream has not taken wins over a new result.
            if (w_last) begin
                if (!r_tvalid || m_axis_tready) begin
                    r_tdata  <= AXIS_TDATA_WIDTH'({w_lane_b, w_lane_a});
                    r_tvalid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign sts_overflow  = r_overflow;

endmodule
